// File: rtl/qtable_update_sched.sv
// Feedback-packet scheduler in front of the Q-table updater: type filter, FIFO, one-at-a-time dispatch with watchdog.
// Optional build macro QSCHED_COALESCE_EN merges a new packet into a queued entry with the same source ID.
module qtable_update_sched #(
  parameter int             WORD_WIDTH     = 16,
  parameter int             FIFO_DEPTH     = 4,
  parameter int             PTR_W          = 2,
  parameter logic [7:0]     TYPE_MASK      = 8'b0000_0110,
  parameter int             TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [WORD_WIDTH-1:0] pSourceID,
  input  logic [WORD_WIDTH-1:0] pClusterID,
  input  logic [WORD_WIDTH-1:0] pEnergyLeft,
  input  logic [WORD_WIDTH-1:0] pQValue,
  input  logic [2:0]            pPacketType,
  input  logic                  flush,
  output logic                  upd_en,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fClusterID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [2:0]            packetType,
  input  logic                  upd_done,
  output logic                  busy,
  output logic                  sched_done,
  output logic                  timeout_err,
  output logic                  spurious_done,
  output logic [WORD_WIDTH-1:0] processed_count,
  output logic [WORD_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {stIdle, stWait, stDone} stateT;

  localparam logic [PTR_W:0]        DEPTH_L      = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [WORD_WIDTH-1:0] TIMEOUT_LAST = WORD_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WORD_WIDTH-1:0] srcMem [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] cluMem [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] engMem [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] qMem   [FIFO_DEPTH];
  logic [2:0]            typeMem[FIFO_DEPTH];

  logic [PTR_W-1:0]      rdPtr, wrPtr, writeIdx, coalesceIdx;
  logic [PTR_W:0]        count;
  logic                  full, empty, typePass, push, filterDrop, store;
  logic                  coalesceHit, writeEn, pop, doneHit, timeoutHit;
  logic [WORD_WIDTH-1:0] waitCnt;
  logic [WORD_WIDTH:0]   dropSum;
  stateT                 state, stateNext;

  assign full       = (count == DEPTH_L);
  assign empty      = (count == '0);
  assign pkt_ready  = !full;
  assign typePass   = TYPE_MASK[pPacketType];
  assign push       = pkt_valid && pkt_ready;
  assign filterDrop = push && !typePass;
  assign pop        = (state == stIdle) && !empty;
  assign doneHit    = (state == stWait) && upd_done;
  assign timeoutHit = (state == stWait) && !upd_done && (waitCnt == TIMEOUT_LAST);
  assign busy       = (state == stWait);
  assign sched_done = (state == stDone);

`ifdef QSCHED_COALESCE_EN
  // Scan youngest to oldest so the oldest match wins; the head being popped this cycle is already dispatched.
  always_comb begin
    coalesceHit = 1'b0;
    coalesceIdx = rdPtr;
    for (int i = FIFO_DEPTH - 1; i >= 0; i--) begin
      if (((PTR_W+1)'(i) < count) && !(pop && (i == 0)) &&
          (srcMem[rdPtr + PTR_W'(i)] == pSourceID)) begin
        coalesceHit = 1'b1;
        coalesceIdx = rdPtr + PTR_W'(i);
      end
    end
    if (!(push && typePass) || flush) coalesceHit = 1'b0;
  end
`else
  assign coalesceHit = 1'b0;
  assign coalesceIdx = rdPtr;
`endif

  assign store    = push && typePass && !flush && !coalesceHit;
  assign writeEn  = store || coalesceHit;
  assign writeIdx = coalesceHit ? coalesceIdx : wrPtr;

  always_ff @(posedge clock) begin
    if (writeEn) begin
      srcMem[writeIdx]  <= pSourceID;
      cluMem[writeIdx]  <= pClusterID;
      engMem[writeIdx]  <= pEnergyLeft;
      qMem[writeIdx]    <= pQValue;
      typeMem[writeIdx] <= pPacketType;
    end
  end

  // Flush clears occupancy but still lets a pop from the old head complete its dispatch.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (store) wrPtr <= wrPtr + 1'b1;
      if (pop)   rdPtr <= rdPtr + 1'b1;
      count <= count + (PTR_W+1)'(store) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= stIdle;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      stIdle:  if (!empty) stateNext = stWait;
      stWait: begin
        if (upd_done)                     stateNext = stDone;
        else if (waitCnt == TIMEOUT_LAST) stateNext = stIdle;
      end
      stDone:  stateNext = stIdle;
      default: stateNext = stIdle;
    endcase
  end

  assign dropSum = {1'b0, drop_count} + (WORD_WIDTH+1)'(filterDrop) + (WORD_WIDTH+1)'(timeoutHit);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      upd_en          <= 1'b0;
      fSourceID       <= '0;
      fClusterID      <= '0;
      fEnergyLeft     <= '0;
      fQValue         <= '0;
      packetType      <= '0;
      waitCnt         <= '0;
      timeout_err     <= 1'b0;
      spurious_done   <= 1'b0;
      processed_count <= '0;
      drop_count      <= '0;
    end else begin
      upd_en <= pop;
      if (pop) begin
        fSourceID   <= srcMem[rdPtr];
        fClusterID  <= cluMem[rdPtr];
        fEnergyLeft <= engMem[rdPtr];
        fQValue     <= qMem[rdPtr];
        packetType  <= typeMem[rdPtr];
      end
      waitCnt <= (state == stWait) ? waitCnt + 1'b1 : '0;
      if (timeoutHit) timeout_err <= 1'b1;
      if (upd_done && (state != stWait)) spurious_done <= 1'b1;
      if (doneHit && (processed_count != '1)) processed_count <= processed_count + 1'b1;
      drop_count <= dropSum[WORD_WIDTH] ? '1 : dropSum[WORD_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_qtable_update_sched.sv
// Directed self-checking bench for qtable_update_sched; also exercises QSCHED_COALESCE_EN when defined.
module tb_qtable_update_sched;

  logic        clock = 1'b0;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [15:0] pSourceID, pClusterID, pEnergyLeft, pQValue;
  logic [2:0]  pPacketType;
  logic        flush;
  logic        upd_en;
  logic [15:0] fSourceID, fClusterID, fEnergyLeft, fQValue;
  logic [2:0]  packetType;
  logic        upd_done;
  logic        busy, sched_done, timeout_err, spurious_done;
  logic [15:0] processed_count, drop_count;

  int assertCount = 0;
  int failCount   = 0;

  qtable_update_sched dut (
    .clock(clock), .rst(rst),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pSourceID(pSourceID), .pClusterID(pClusterID), .pEnergyLeft(pEnergyLeft),
    .pQValue(pQValue), .pPacketType(pPacketType),
    .flush(flush), .upd_en(upd_en),
    .fSourceID(fSourceID), .fClusterID(fClusterID), .fEnergyLeft(fEnergyLeft),
    .fQValue(fQValue), .packetType(packetType),
    .upd_done(upd_done), .busy(busy), .sched_done(sched_done),
    .timeout_err(timeout_err), .spurious_done(spurious_done),
    .processed_count(processed_count), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] src,
                               input logic [15:0] q, input logic [2:0] typ);
    pkt_valid   = v;
    pSourceID   = src;
    pClusterID  = src + 16'h0100;
    pEnergyLeft = 16'h0200;
    pQValue     = q;
    pPacketType = typ;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next dispatch, checks it, then completes it with a one-cycle done.
  task automatic serveOne(input string tag, input logic [15:0] expId, input logic [15:0] expQ);
    for (int n = 0; n < 8 && !upd_en; n++) tick();
    checkOutput({tag, "_upd_en"}, 16'(upd_en), 16'd1);
    checkOutput({tag, "_src"}, fSourceID, expId);
    checkOutput({tag, "_q"}, fQValue, expQ);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    upd_done = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
    #12;
    checkOutput("rst_ready", 16'(pkt_ready), 16'd1);
    checkOutput("rst_upd_en", 16'(upd_en), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_processed", processed_count, 16'd0);
    checkOutput("rst_drop", drop_count, 16'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    tick();

    $display("[TB] single packet");
    applyStimulus(1'b1, 16'h0005, 16'h0040, 3'd1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
    checkOutput("single_no_early_en", 16'(upd_en), 16'd0);
    tick();
    checkOutput("single_upd_en", 16'(upd_en), 16'd1);
    checkOutput("single_src", fSourceID, 16'h0005);
    checkOutput("single_cluster", fClusterID, 16'h0105);
    checkOutput("single_q", fQValue, 16'h0040);
    checkOutput("single_type", 16'(packetType), 16'd1);
    checkOutput("single_busy", 16'(busy), 16'd1);
    tick();
    checkOutput("single_en_pulse", 16'(upd_en), 16'd0);
    tick();
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    checkOutput("single_sched_done", 16'(sched_done), 16'd1);
    tick();
    checkOutput("single_sched_done_pulse", 16'(sched_done), 16'd0);
    checkOutput("single_processed", processed_count, 16'd1);
    checkOutput("single_no_spurious", 16'(spurious_done), 16'd0);

    $display("[TB] filter");
    applyStimulus(1'b1, 16'h0044, 16'h0001, 3'd0);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
    checkOutput("filter_drop", drop_count, 16'd1);
    tick();
    checkOutput("filter_no_en", 16'(upd_en), 16'd0);
    checkOutput("filter_no_busy", 16'(busy), 16'd0);

    $display("[TB] backpressure");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 16'h0011 + 16'(k), 16'h0100 + 16'(k), 3'd2);
      tick();
    end
    checkOutput("bp_full", 16'(pkt_ready), 16'd0);
    applyStimulus(1'b1, 16'h0016, 16'h0106, 3'd2);
    tick();
    checkOutput("bp_stalled", 16'(pkt_ready), 16'd0);
    checkOutput("bp_inflight", fSourceID, 16'h0011);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    checkOutput("bp_sched_done", 16'(sched_done), 16'd1);
    tick();
    checkOutput("bp_still_full", 16'(pkt_ready), 16'd0);
    tick();
    checkOutput("bp_next_en", 16'(upd_en), 16'd1);
    checkOutput("bp_next_src", fSourceID, 16'h0012);
    checkOutput("bp_ready_again", 16'(pkt_ready), 16'd1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
    checkOutput("bp_sixth_taken", 16'(pkt_ready), 16'd0);
    checkOutput("bp_processed", processed_count, 16'd2);

    $display("[TB] timeout");
    repeat (62) tick();
    checkOutput("to_not_early", 16'(timeout_err), 16'd0);
    checkOutput("to_still_busy", 16'(busy), 16'd1);
    tick();
    checkOutput("to_err", 16'(timeout_err), 16'd1);
    checkOutput("to_drop", drop_count, 16'd2);
    checkOutput("to_idle", 16'(busy), 16'd0);
    tick();
    checkOutput("to_next_en", 16'(upd_en), 16'd1);
    checkOutput("to_next_src", fSourceID, 16'h0013);

    $display("[TB] flush");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_ready", 16'(pkt_ready), 16'd1);
    checkOutput("flush_inflight", 16'(busy), 16'd1);
    checkOutput("flush_src_hold", fSourceID, 16'h0013);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    checkOutput("flush_sched_done", 16'(sched_done), 16'd1);
    tick();
    tick();
    checkOutput("flush_empty_no_en", 16'(upd_en), 16'd0);
    checkOutput("flush_empty_idle", 16'(busy), 16'd0);
    checkOutput("flush_processed", processed_count, 16'd3);

    $display("[TB] spurious done");
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    checkOutput("spurious_set", 16'(spurious_done), 16'd1);
    checkOutput("spurious_no_count", processed_count, 16'd3);

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 16'h0021, 16'h0007, 3'd1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
    tick();
    checkOutput("rw_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("rw_busy_cleared", 16'(busy), 16'd0);
    checkOutput("rw_upd_en", 16'(upd_en), 16'd0);
    checkOutput("rw_ready", 16'(pkt_ready), 16'd1);
    checkOutput("rw_src", fSourceID, 16'h0000);
    checkOutput("rw_timeout", 16'(timeout_err), 16'd0);
    checkOutput("rw_spurious", 16'(spurious_done), 16'd0);
    checkOutput("rw_drop", drop_count, 16'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    tick();
    tick();
    checkOutput("rw_no_redispatch", 16'(upd_en), 16'd0);
    checkOutput("rw_no_sched_done", 16'(sched_done), 16'd0);

    $display("[TB] same-ID sequence");
    applyStimulus(1'b1, 16'h0030, 16'h0003, 3'd1);
    tick();
    applyStimulus(1'b1, 16'h0007, 16'h0011, 3'd2);
    tick();
    applyStimulus(1'b1, 16'h0009, 16'h0022, 3'd1);
    tick();
    applyStimulus(1'b1, 16'h0007, 16'h0055, 3'd2);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
    checkOutput("seq_first_src", fSourceID, 16'h0030);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    tick();
`ifdef QSCHED_COALESCE_EN
    serveOne("co_id7", 16'h0007, 16'h0055);
    serveOne("co_id9", 16'h0009, 16'h0022);
    tick();
    tick();
    checkOutput("co_no_third", 16'(upd_en), 16'd0);
    checkOutput("co_idle", 16'(busy), 16'd0);
    checkOutput("co_processed", processed_count, 16'd3);
`else
    serveOne("ap_id7a", 16'h0007, 16'h0011);
    serveOne("ap_id9", 16'h0009, 16'h0022);
    serveOne("ap_id7b", 16'h0007, 16'h0055);
    tick();
    tick();
    checkOutput("ap_idle", 16'(busy), 16'd0);
    checkOutput("ap_processed", processed_count, 16'd4);
`endif
    checkOutput("seq_drop", drop_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/qtable_update_sched.md
Name: qtable_update_sched

Overview:
- Scheduler in front of the Q-table update engine.
- Buffers incoming feedback packets (source ID, cluster ID, energy, Q-value, packet type) in a small FIFO.
- Filters packets by type, dispatches one packet at a time to the updater with a one-cycle enable, then waits for the updater's done.
- Enforces a watchdog timeout and keeps processed/drop statistics for the node controller.

Parameters:
- WORD_WIDTH, 16, width of every packet field and counter
- FIFO_DEPTH, 4, packet buffer entries (power of 2)
- PTR_W, 2, log2(FIFO_DEPTH)
- TYPE_MASK, 8'b0000_0110, bit t set means packet type t is dispatched
- TIMEOUT_CYCLES, 64, WAIT-state cycles before abort

Ports:
- clock  in  1  system clock; all flops rising edge
- rst  in  1  asynchronous active-high reset
- pkt_valid  in  1  packet present on pkt_* inputs
- pkt_ready  out  1  scheduler can accept a packet
- pSourceID, pClusterID, pEnergyLeft, pQValue  in  WORD_WIDTH each  incoming packet fields
- pPacketType  in  3  incoming packet type
- flush  in  1  synchronous FIFO clear
- upd_en  out  1  one-cycle start pulse to the updater
- fSourceID, fClusterID, fEnergyLeft, fQValue  out  WORD_WIDTH each  dispatched packet fields to the updater
- packetType  out  3  dispatched packet type
- upd_done  in  1  updater completion
- busy  out  1  high while a packet is in flight (WAIT)
- sched_done  out  1  one-cycle pulse when a dispatched packet completes
- timeout_err  out  1  sticky; cleared only by rst
- spurious_done  out  1  sticky; upd_done seen outside WAIT
- processed_count  out  WORD_WIDTH  completed packets, saturating at 0xFFFF
- drop_count  out  WORD_WIDTH  filtered plus timed-out packets, saturating at 0xFFFF

Behaviour:
- Reset: every output 0 except pkt_ready=1. FIFO empty, state IDLE. An asserted rst aborts any in-flight packet immediately, with no sched_done.
- Push handshake:
  - A push occurs when pkt_valid && pkt_ready at a clock edge.
  - pkt_ready = !full, driven from registered count. A pop in the same cycle does not raise ready that cycle.
  - A push with TYPE_MASK[pPacketType]=0 is consumed and not stored; drop_count increments.
- flush: count/pointers go to 0 at the next edge. Pushes in that cycle are lost. An in-flight packet is unaffected.
- FSM IDLE / WAIT / DONE:
  - IDLE: if FIFO is not empty at edge E, pop the head, latch all five f*/packetType outputs, set upd_en=1, go to WAIT. upd_en deasserts at E+1.
  - Latency: a push at edge E0 into an empty FIFO in IDLE gives upd_en high for the cycle after E1.
  - WAIT: busy=1; wait_cnt increments each cycle. upd_done sampled high moves to DONE. If wait_cnt reaches TIMEOUT_CYCLES without done: timeout_err=1, drop_count++, go to IDLE. Done takes priority over timeout on the same edge.
  - DONE: sched_done=1 for one cycle, processed_count++, back to IDLE. The next dispatch follows no earlier than the following edge.
  - f* outputs hold the last dispatched values until the next dispatch.
- upd_done outside WAIT sets spurious_done and is otherwise ignored.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- QSCHED_COALESCE_EN
- Defined: an accepted, type-passing push whose pSourceID matches a queued, not-yet-dispatched entry overwrites that entry's fields in place. Count is unchanged; no counter changes. The match uses the oldest entry if several match. pkt_ready is still !full.
- Undefined: every accepted packet is appended.

Test Plan:
- Single packet: push type 1, ID 0x0005, Q 0x0040 into an idle block → upd_en one cycle after the next edge, fSourceID=0x0005. Respond upd_done after 3 cycles → sched_done pulse, processed_count=1.
- Backpressure: push 5 packets with upd_done held 0 → pkt_ready=0 after 4 are buffered (1 in flight + 3 queued? no: the first is popped, so 5 are accepted). The 6th is stalled until DONE.
- Filter: push type 0 → not dispatched, drop_count=1, no upd_en.
- Timeout: dispatch and never assert upd_done → after 64 WAIT cycles timeout_err=1, drop_count=1, next queued packet dispatched.
- Spurious/reset: upd_done in IDLE → spurious_done=1. Assert rst during WAIT → all outputs 0, pkt_ready=1.
- Coalesce (macro defined): queue IDs 7, 9, then 7 with Q 0x0055 while busy → two entries dispatched; the ID-7 dispatch carries fQValue=0x0055.
